// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned MEM_DEPTH = 6;
  localparam int unsigned RESET_PC  = 0;

endpackage

// File: rtl/pc_next_logic.sv
// Next program-counter selection: redirect beats sequential fetch, fetch wraps at MEM_DEPTH-1.
module pc_next_logic
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W     = fetch_pkg::ADDR_W,
  parameter int unsigned PC_DEPTH = fetch_pkg::MEM_DEPTH
) (
  input  logic [PC_W-1:0] pc,
  input  logic            load,
  input  logic            redirect,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] next_pc,
  output logic            illegal_target
);

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PC_DEPTH - 1);

  logic out_of_range;

  assign out_of_range   = (target > LAST_PC);
  assign illegal_target = redirect & out_of_range;

  always_comb begin
    next_pc = pc;
    if (redirect) begin
      // An illegal target leaves the pc untouched; the caller halts instead.
      if (!out_of_range) next_pc = target;
    end else if (load) begin
      next_pc = (pc == LAST_PC) ? '0 : pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the pc, registers instruction_data and presents it over valid/ready.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W    = fetch_pkg::ADDR_W,
  parameter int unsigned DATA_W    = fetch_pkg::DATA_W,
  parameter int unsigned MEM_DEPTH = fetch_pkg::MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] instruction_address,
  input  logic [DATA_W-1:0] instruction_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              busy,
  output logic              fault
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic              running;
  logic              load;
  logic              redirect;
  logic              illegal;
  logic              accept;

  assign running  = (state == RUN);
  assign accept   = out_valid & out_ready;
  assign redirect = running & ~halt_req & redirect_valid;
  assign load     = running & ~halt_req & ~redirect_valid & (~out_valid | out_ready);

  assign instruction_address = pc;
  assign busy                = running;

  pc_next_logic #(
    .PC_W     (ADDR_W),
    .PC_DEPTH (MEM_DEPTH)
  ) u_pc_next (
    .pc             (pc),
    .load           (load),
    .redirect       (redirect),
    .target         (redirect_target),
    .next_pc        (next_pc),
    .illegal_target (illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= ADDR_W'(RESET_PC);
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      fault     <= 1'b0;
    end else begin
      pc <= next_pc;

      // Redirect flushes the held word even when decode accepts it this edge.
      if (load) begin
        out_instr <= instruction_data;
        out_pc    <= pc;
        out_valid <= 1'b1;
      end else if (redirect || accept) begin
        out_valid <= 1'b0;
      end

      if (illegal) fault <= 1'b1;

      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (halt_req || illegal) state <= HALT;
        HALT:    if (start) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed plan plus random traffic against a behavioural model.
module tb_instruction_fetch;

  localparam int DEPTH = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, halt_req, redirect_valid, out_ready;
  logic [7:0] redirect_target;
  logic [7:0] instruction_address;
  logic [7:0] instruction_data;
  logic       out_valid;
  logic [7:0] out_instr;
  logic [7:0] out_pc;
  logic       busy, fault;

  logic [7:0] mem [DEPTH];

  int tests_run = 0;
  int tests_failed = 0;
  bit chk_en = 1'b0;

  typedef struct {
    int         st;      // 0 idle, 1 run, 2 halt
    logic [7:0] pc;
    bit         v;
    logic [7:0] instr;
    logic [7:0] opc;
    bit         fault;
  } model_t;

  model_t m;

  always #5 clk = ~clk;

  assign instruction_data = (instruction_address < 8'(DEPTH)) ? mem[instruction_address] : 8'h00;

  instruction_fetch #(
    .ADDR_W    (8),
    .DATA_W    (8),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .halt_req            (halt_req),
    .redirect_valid      (redirect_valid),
    .redirect_target     (redirect_target),
    .instruction_address (instruction_address),
    .instruction_data    (instruction_data),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_instr           (out_instr),
    .out_pc              (out_pc),
    .busy                (busy),
    .fault               (fault)
  );

  function automatic model_t model_reset();
    model_t r;
    r.st = 0; r.pc = 8'd0; r.v = 1'b0; r.instr = 8'h00; r.opc = 8'h00; r.fault = 1'b0;
    return r;
  endfunction

  function automatic model_t model_step(model_t c, bit s, bit h, bit rv, logic [7:0] tgt, bit rdy);
    model_t n = c;
    bit taken = c.v && rdy;
    case (c.st)
      0: if (s) n.st = 1;
      2: begin
        if (s) n.st = 1;
        if (taken) n.v = 1'b0;
      end
      default: begin
        if (h) begin
          n.st = 2;
          if (taken) n.v = 1'b0;
        end else if (rv) begin
          n.v = 1'b0;
          if (int'(tgt) < DEPTH) n.pc = tgt;
          else begin
            n.fault = 1'b1;
            n.st = 2;
          end
        end else if (!c.v || rdy) begin
          n.instr = mem[c.pc];
          n.opc   = c.pc;
          n.v     = 1'b1;
          n.pc    = 8'((int'(c.pc) + 1) % DEPTH);
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else m <= model_step(m, start, halt_req, redirect_valid, redirect_target, out_ready);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_addr",  32'(instruction_address), 32'(m.pc));
      check("m_valid", 32'(out_valid), 32'(m.v));
      check("m_instr", 32'(out_instr), 32'(m.instr));
      check("m_pc",    32'(out_pc), 32'(m.opc));
      check("m_busy",  32'(busy), 32'(m.st == 1));
      check("m_fault", 32'(fault), 32'(m.fault));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string name, input logic [7:0] pc_e, input logic [7:0] instr_e);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_pc"},    32'(out_pc),    32'(pc_e));
    check({name, "_instr"}, 32'(out_instr), 32'(instr_e));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'((i + 1) * 8'h11);
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
    redirect_target = 8'd0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_addr",  32'(instruction_address), 32'd0);

    // Stream with wrap
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy",  32'(busy), 32'd1);
    check("start_valid", 32'(out_valid), 32'd0);
    tick(); expect_out("s0", 8'd0, 8'h11);
    tick(); expect_out("s1", 8'd1, 8'h22);
    tick(); expect_out("s2", 8'd2, 8'h33);
    tick(); expect_out("s3", 8'd3, 8'h44);
    tick(); expect_out("s4", 8'd4, 8'h55);
    tick(); expect_out("s5", 8'd5, 8'h66);
    tick(); expect_out("wrap", 8'd0, 8'h11);
    tick(); tick(); expect_out("pre_stall", 8'd2, 8'h33);

    // Stall for three edges
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("stall", 8'd2, 8'h33);
      check("stall_addr", 32'(instruction_address), 32'd3);
    end
    out_ready = 1'b1;
    tick(); expect_out("unstall", 8'd3, 8'h44);

    // Legal redirect while out_pc=1 is presented
    tick(); tick(); tick(); tick(); expect_out("pre_redir", 8'd1, 8'h22);
    redirect_valid = 1'b1; redirect_target = 8'd4;
    tick();
    redirect_valid = 1'b0;
    check("redir_valid", 32'(out_valid), 32'd0);
    check("redir_addr",  32'(instruction_address), 32'd4);
    tick(); expect_out("redir_load", 8'd4, 8'h55);

    // Illegal redirect from pc=5
    redirect_valid = 1'b1; redirect_target = 8'd7;
    tick();
    redirect_valid = 1'b0;
    check("ill_fault", 32'(fault), 32'd1);
    check("ill_busy",  32'(busy), 32'd0);
    check("ill_valid", 32'(out_valid), 32'd0);
    check("ill_addr",  32'(instruction_address), 32'd5);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); expect_out("resume", 8'd5, 8'h66);
    check("fault_sticky", 32'(fault), 32'd1);

    // halt_req beats redirect at pc=3
    tick(); tick(); tick(); expect_out("pre_halt", 8'd2, 8'h33);
    halt_req = 1'b1; redirect_valid = 1'b1; redirect_target = 8'd0;
    tick();
    halt_req = 1'b0; redirect_valid = 1'b0;
    check("halt_busy", 32'(busy), 32'd0);
    check("halt_addr", 32'(instruction_address), 32'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); expect_out("halt_resume", 8'd3, 8'h44);

    // Async reset mid-stream
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_addr",  32'(instruction_address), 32'd0);
    check("arst_fault", 32'(fault), 32'd0);
    check("arst_busy",  32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("idle_busy",  32'(busy), 32'd0);
    check("idle_valid", 32'(out_valid), 32'd0);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      start          = ($urandom_range(0, 9) == 0);
      halt_req       = ($urandom_range(0, 11) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_target = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(6, 255))
                                                    : 8'($urandom_range(0, 5));
      out_ready      = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of instruction_mem.
- Holds the program counter and drives instruction_address to instruction_mem.
- Captures the combinational instruction_data into an output instruction register.
- Presents {instruction, pc} to decode over a valid/ready handshake; supports start, halt and branch redirect.

Parameters:
ADDR_W, 8, width of program counter / instruction_address
DATA_W, 8, width of instruction word
MEM_DEPTH, 6, number of valid instruction words; legal PC range 0..MEM_DEPTH-1

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  pulse: leave IDLE and begin fetching at PC 0
halt_req  input  1  pulse: stop fetching, enter HALT
redirect_valid  input  1  branch/jump request this cycle
redirect_target  input  ADDR_W  new PC on redirect
instruction_address  output  ADDR_W  to instruction_mem; equals pc register
instruction_data  input  DATA_W  from instruction_mem; combinational read of instruction_address
out_valid  output  1  out_instr/out_pc hold a valid fetched instruction
out_ready  input  1  decode accepts when out_valid and out_ready are both 1 at a clock edge
out_instr  output  DATA_W  registered instruction word
out_pc  output  ADDR_W  address out_instr was fetched from
busy  output  1  1 in RUN state
fault  output  1  sticky; set on out-of-range redirect, cleared only by reset

Behaviour:
- Reset (rst_n low, async): state=IDLE, pc=0, out_valid=0, out_instr=0, out_pc=0, fault=0, busy=0. Reset mid-operation discards any held instruction.
- States: IDLE, RUN, HALT.
  - IDLE -> RUN on start.
  - RUN -> HALT on halt_req or on an illegal redirect.
  - HALT -> RUN on start; pc is kept and the held out_valid instruction is kept.
  - start in RUN is ignored. halt_req in IDLE/HALT is ignored.
- instruction_address = pc at all times (combinational from the register, no extra delay).
- In RUN, priority per clock edge is halt_req > redirect_valid > fetch.
- Fetch (load) condition: RUN and no halt_req and no redirect_valid and (out_valid==0 or out_ready==1). On load:
  - out_instr <= instruction_data; out_pc <= pc; out_valid <= 1.
  - pc <= (pc==MEM_DEPTH-1) ? 0 : pc+1 (wrap-around).
- Throughput and latency: one instruction per cycle while out_ready=1. Latency from start to first out_valid is 1 edge after the start edge (start edge enters RUN, next edge loads PC 0).
- Stall: out_valid=1 and out_ready=0 -> out_instr, out_pc, out_valid and pc all hold.
- Accept without reload: out_valid=1 and out_ready=1 and no load this cycle -> out_valid <= 0.
- Redirect (RUN, no halt_req):
  - target <= MEM_DEPTH-1: pc <= target and out_valid <= 0 (the held instruction is flushed, even if out_ready=1 this cycle). The next edge loads the target.
  - target >= MEM_DEPTH: fault <= 1, state <= HALT, out_valid <= 0, pc unchanged.
  - redirect_valid outside RUN is ignored.
- halt_req in RUN: state <= HALT and no load this edge. A held out_valid instruction stays presented and can still be accepted in HALT, which clears out_valid.
- busy = (state==RUN).

Decomposition:
- Shared package fetch_pkg:
  - state enum (IDLE, RUN, HALT)
  - ADDR_W / DATA_W / MEM_DEPTH constants
  - RESET_PC = 0
- One sub-module is natural: pc_next_logic, a combinational module computing the next pc from (pc, load, redirect, target) with wrap and range check. It outputs next_pc and illegal_target.
- instruction_mem is instantiated by the parent, not inside this block.

Test Plan:
- Memory preloaded 0x11,0x22,0x33,0x44,0x55,0x66; reset then start, out_ready=1 -> out_pc 0,1,2,3,4,5,0 on consecutive cycles with out_instr 0x11..0x66,0x11, plus wrap check.
- After out_pc=2 is presented, drop out_ready for 3 cycles -> out_pc=2, out_instr=0x33 and instruction_address=3 hold; raise out_ready -> next out_pc=3.
- While out_valid with out_pc=1, redirect_valid=1 with target=4 -> next cycle out_valid=0, instruction_address=4; following cycle out_pc=4, out_instr=0x55.
- Redirect target=7 -> fault=1, busy=0, out_valid=0 and pc unchanged; start -> fetch resumes from the unchanged pc and fault stays 1.
- halt_req and redirect_valid (target 0) in the same cycle at pc=3 -> HALT, pc stays 3, no redirect applied; start -> out_pc=3 next.
- Assert rst_n low asynchronously mid-stream with out_valid=1 -> out_valid, pc and fault go to 0 immediately without a clock edge; state IDLE until start.
